// File: rtl/mem_dump_tx.sv
// Purpose : walks all 16 RAM words and sends each as an ASCII hex line "A:DD\r\n" over a UART TX line (8N1).
// Latency : per line 3 cycles (REQ/READ/CAPT) + 60 bit periods; grant waits add to REQ.
// Backpressure: bus_req/bus_gnt handshake; the FSM parks in REQ until granted, and start is ignored while busy.
//
// Ports:
//   clk, CLR           - system clock, synchronous active-high reset
//   start, halted      - dump request pulse, accepted only when halted is high
//   bus_req, bus_gnt   - RAM read path request and grant
//   rd_en, rd_addr     - one-cycle read strobe and address; rd_data returns the following cycle
//   tx                 - UART serial line, idles high
//   busy, done         - dump in progress, one-cycle completion pulse
//
// Optional build macro DUMP_CHECKSUM_EN: appends a line "S:SS\r\n" carrying the mod-256 sum of all 16 bytes.
module mem_dump_tx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       CLR,
    input  logic       start,
    input  logic       halted,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic       rd_en,
    output logic [3:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    localparam int BIT_DIV = CLK_HZ / BAUD;
    localparam int CW      = (BIT_DIV > 2) ? $clog2(BIT_DIV) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(BIT_DIV - 2);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_READ = 3'd2;
    localparam logic [2:0] S_CAPT = 3'd3;
    localparam logic [2:0] S_SEND = 3'd4;
    localparam logic [2:0] S_NEXT = 3'd5;
    localparam logic [2:0] S_FIN  = 3'd6;

    logic [2:0]      r_state;
    logic [3:0]      r_addr;
    logic [5:0][7:0] r_line;   // character 0 is sent first
    logic [2:0]      r_char;
    logic [3:0]      r_bit;    // 0 = start, 1..8 = data LSB first, 9 = stop
    logic [CW-1:0]   r_baud;
`ifdef DUMP_CHECKSUM_EN
    logic [7:0]      r_sum;
    logic            r_sum_sent;
`endif

    logic [7:0] w_cur_char;
    logic [2:0] w_data_idx;
    logic       w_bit_val;
    logic       w_last_bit;

    function automatic logic [7:0] f_hex(input logic [3:0] n);
        f_hex = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    assign w_cur_char = r_line[r_char];
    assign w_data_idx = 3'(r_bit - 4'd1);
    assign w_last_bit = (r_char == 3'd5) && (r_bit == 4'd9);

    always_comb begin
        w_bit_val = 1'b1;
        if (r_bit == 4'd0)
            w_bit_val = 1'b0;
        else if (r_bit != 4'd9)
            w_bit_val = w_cur_char[w_data_idx];
    end

    assign bus_req = (r_state == S_REQ) || (r_state == S_READ) || (r_state == S_CAPT);
    assign rd_en   = (r_state == S_READ);
    assign rd_addr = r_addr;
    assign tx      = (r_state == S_SEND) ? w_bit_val : 1'b1;
    assign busy    = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done    = (r_state == S_FIN);

    always_ff @(posedge clk) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_line  <= '0;
            r_char  <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
`ifdef DUMP_CHECKSUM_EN
            r_sum      <= '0;
            r_sum_sent <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && halted) begin
                        r_addr  <= '0;
`ifdef DUMP_CHECKSUM_EN
                        r_sum      <= '0;
                        r_sum_sent <= 1'b0;
`endif
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus_gnt)
                        r_state <= S_READ;
                end
                S_READ: r_state <= S_CAPT;
                S_CAPT: begin
                    r_line  <= {8'h0A, 8'h0D, f_hex(rd_data[3:0]), f_hex(rd_data[7:4]),
                                8'h3A, f_hex(r_addr)};
`ifdef DUMP_CHECKSUM_EN
                    r_sum   <= r_sum + rd_data;
`endif
                    r_char  <= '0;
                    r_bit   <= '0;
                    r_baud  <= '0;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    // The final stop bit's last clock is spent in NEXT (tx is high
                    // there too), so a line costs exactly 60 bit periods plus 3.
                    if (w_last_bit && (r_baud == BAUD_PRE)) begin
                        r_state <= S_NEXT;
                    end else if (r_baud == BAUD_LAST) begin
                        r_baud <= '0;
                        if (r_bit == 4'd9) begin
                            r_bit  <= '0;
                            r_char <= r_char + 3'd1;
                        end else begin
                            r_bit <= r_bit + 4'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (r_addr == 4'hF) begin
`ifdef DUMP_CHECKSUM_EN
                        if (!r_sum_sent) begin
                            r_line     <= {8'h0A, 8'h0D, f_hex(r_sum[3:0]), f_hex(r_sum[7:4]),
                                           8'h3A, 8'h53};
                            r_sum_sent <= 1'b1;
                            r_char     <= '0;
                            r_bit      <= '0;
                            r_baud     <= '0;
                            r_state    <= S_SEND;
                        end else begin
                            r_state <= S_FIN;
                        end
`else
                        r_state <= S_FIN;
`endif
                    end else begin
                        r_addr  <= r_addr + 4'd1;
                        r_state <= S_REQ;
                    end
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_dump_tx.sv
module tb_mem_dump_tx;
    localparam int BD = 10;
`ifdef DUMP_CHECKSUM_EN
    localparam int EXP_LINES = 17;
    localparam int EXP_DONE  = 10248;
`else
    localparam int EXP_LINES = 16;
    localparam int EXP_DONE  = 9648;
`endif

    logic       clk = 1'b0;
    logic       CLR = 1'b1;
    logic       start = 1'b0;
    logic       halted = 1'b1;
    logic       bus_req;
    logic       bus_gnt = 1'b1;
    logic       rd_en;
    logic [3:0] rd_addr;
    logic [7:0] rd_data = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    mem_dump_tx #(.CLK_HZ(1000), .BAUD(100)) dut (
        .clk(clk), .CLR(CLR), .start(start), .halted(halted),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .tx(tx), .busy(busy), .done(done)
    );

    // RAM preload: word i holds i*0x11
    logic [7:0] mem [16];
    initial for (int i = 0; i < 16; i++) mem[i] = 8'(i * 17);
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    logic [7:0] hexd [16] = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                              8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

    int total = 0;
    int bad = 0;
    int lines_seen = 0;
    int done_cnt = 0;
    bit mon_en = 1'b1;
    logic [7:0] exp_q [$];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_line(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
        exp_q.push_back(a);
        exp_q.push_back(8'h3A);
        exp_q.push_back(h);
        exp_q.push_back(l);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic push_dump();
        // word i = i*0x11, so both data digits equal the address digit
        for (int a = 0; a < 16; a++) push_line(hexd[a], hexd[a], hexd[a]);
`ifdef DUMP_CHECKSUM_EN
        push_line(8'h53, 8'h46, 8'h38); // "S:F8"
`endif
    endtask

    // UART receiver + scoreboard check
    initial begin
        logic [7:0] b;
        logic stp;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                repeat (4) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BD) @(negedge clk);
                    b[i] = tx;
                end
                repeat (BD) @(negedge clk);
                stp = tx;
                if (mon_en) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_char: got %h expected none", b);
                    end else begin
                        e = exp_q.pop_front();
                        if (b !== e || stp !== 1'b1) begin
                            bad++;
                            $display("FAIL char line=%0d: got %h stop=%b expected %h stop=1",
                                     lines_seen, b, stp, e);
                        end
                    end
                    if (b == 8'h0A) lines_seen++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done; optionally re-pulses start mid-dump; counts cycles with busy low.
    task automatic wait_done(input int limit, input int restart_at, output int cyc, output int busy_lo);
        cyc = 0;
        busy_lo = 0;
        while (done !== 1'b1 && cyc < limit) begin
            if (busy !== 1'b1) busy_lo++;
            start = (cyc == restart_at) ? 1'b1 : 1'b0;
            tick();
            cyc++;
        end
        start = 1'b0;
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got no done within %0d cycles", limit);
        end
    endtask

    task automatic wait_until_send(input logic [3:0] a, input string name);
        int n;
        n = 0;
        while (!(rd_addr == a && bus_req == 1'b0 && busy == 1'b1) && n < 10000) begin
            tick();
            n++;
        end
        chk(name, 32'(n < 10000), 32'd1);
    endtask

    task automatic post_checks(input string tag, input int lines0, input int done0);
        repeat (30) tick();
        chk({tag, "_lines"}, 32'(lines_seen - lines0), 32'(EXP_LINES));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_done_pulses"}, 32'(done_cnt - done0), 32'd1);
        chk({tag, "_tx_idle"}, 32'(tx), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int cyc, blo, l0, d0, n_req_lo, n_rd, n_tx;

        // reset state
        repeat (3) tick();
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        CLR = 1'b0;
        tick();

        // start ignored while not halted
        halted = 1'b0;
        pulse_start();
        n_tx = 0; blo = 0; n_req_lo = 0;
        for (int i = 0; i < 150; i++) begin
            if (busy !== 1'b0) blo++;
            if (tx !== 1'b1) n_tx++;
            if (bus_req !== 1'b0) n_req_lo++;
            tick();
        end
        chk("gate_busy_cycles", 32'(blo), 32'd0);
        chk("gate_tx_low_cycles", 32'(n_tx), 32'd0);
        chk("gate_bus_req_cycles", 32'(n_req_lo), 32'd0);
        halted = 1'b1;

        // basic dump, with a second start while busy
        l0 = lines_seen; d0 = done_cnt;
        push_dump();
        pulse_start();
        wait_done(20000, 300, cyc, blo);
        chk("basic_done_cycle", 32'(cyc), 32'(EXP_DONE));
        chk("basic_busy_low_cycles", 32'(blo), 32'd0);
        tick();
        chk("basic_busy_after_fin", 32'(busy), 32'd0);
        post_checks("basic", l0, d0);

        // grant stall at address 3
        l0 = lines_seen; d0 = done_cnt;
        push_dump();
        pulse_start();
        wait_until_send(4'd2, "stall_reach_line2");
        bus_gnt = 1'b0;
        cyc = 0;
        while (bus_req !== 1'b1 && cyc < 2000) begin tick(); cyc++; end
        chk("stall_req_seen", 32'(cyc < 2000), 32'd1);
        chk("stall_req_addr", 32'(rd_addr), 32'd3);
        n_req_lo = 0; n_rd = 0; n_tx = 0;
        for (int i = 0; i < 50; i++) begin
            if (bus_req !== 1'b1) n_req_lo++;
            if (rd_en !== 1'b0) n_rd++;
            if (tx !== 1'b1) n_tx++;
            tick();
        end
        chk("stall_req_drop_cycles", 32'(n_req_lo), 32'd0);
        chk("stall_rd_en_cycles", 32'(n_rd), 32'd0);
        chk("stall_tx_low_cycles", 32'(n_tx), 32'd0);
        bus_gnt = 1'b1;
        wait_done(20000, -1, cyc, blo);
        post_checks("stall", l0, d0);

        // reset during line 7, then restart from 0
        push_dump();
        pulse_start();
        wait_until_send(4'd7, "abort_reach_line7");
        repeat (150) tick();
        mon_en = 1'b0;
        CLR = 1'b1;
        tick();
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_bus_req", 32'(bus_req), 32'd0);
        CLR = 1'b0;
        repeat (250) tick();
        exp_q.delete();
        mon_en = 1'b1;
        l0 = lines_seen; d0 = done_cnt;
        push_dump();
        pulse_start();
        wait_done(20000, -1, cyc, blo);
        chk("restart_done_cycle", 32'(cyc), 32'(EXP_DONE));
        post_checks("restart", l0, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
